ctrl_path_arbiter: RTL and testbench
====================================

CTRL_PATH_ARBITER -- requirements
Module: ctrl_path_arbiter

Interface
REQ-001 The block SHALL have parameter C_S_AXIS_DATA_WIDTH, default 512, control-stream data width.
REQ-002 The block SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, control-stream tuser width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles (used only with CTRL_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have these ports: axis_clk  in  1  sole clock; aresetn  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these ports, for each n in {0,1}: sn_axis_tdata  in  C_S_AXIS_DATA_WIDTH  requester-n data; sn_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  tuser; sn_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables; sn_axis_tvalid  in  1  beat valid; sn_axis_tlast  in  1  last beat; sn_axis_tready  out  1  beat accept.
REQ-006 The block SHALL have these ports: c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same widths  merged control stream into stage chain; there is no tready input.
REQ-007 The block SHALL have these ports: cfg_busy  out  1  packet in progress; pkt_cnt  out  32  forwarded-packet count; timeout_err  out  1  sticky watchdog flag.

Function
REQ-008 The block SHALL use FSM states IDLE, GRANT0 and GRANT1.
REQ-009 In IDLE, sn_axis_tready SHALL be 0 and c_m_axis_tvalid SHALL be 0 after the last registered beat drains.
REQ-010 In IDLE, when only sn_axis_tvalid=1, the next state SHALL be GRANTn.
REQ-011 In IDLE, when both tvalids are 1, the block SHALL grant the requester other than last_grant (round-robin); last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-012 In GRANTn, sn_axis_tready SHALL be 1 and the other requester's tready SHALL be 0.
REQ-013 Grants SHALL be packet-atomic: no switch before an accepted beat with tlast=1.
REQ-014 Each accepted beat SHALL appear on c_m_axis_* exactly one cycle later, registered, with tvalid=1 for exactly one cycle.
REQ-015 When no beat is accepted in a cycle, c_m_axis_tvalid SHALL be 0 the next cycle, and tdata/tuser/tkeep/tlast SHALL be driven to 0.
REQ-016 An accepted tlast beat SHALL move the FSM to IDLE the next cycle, load last_grant=n, and increment pkt_cnt.
REQ-017 Each packet switch SHALL therefore cost one bubble cycle; this is required behaviour.
REQ-018 pkt_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 cfg_busy SHALL equal (state != IDLE).
REQ-020 A tvalid deassertion mid-packet SHALL hold the grant with no output beat.

Reset
REQ-021 Asserting aresetn low SHALL immediately force state=IDLE, all c_m_axis_* outputs=0, sn_axis_tready=0, pkt_cnt=0, timeout_err=0, last_grant=1 and watchdog counter=0.
REQ-022 A packet truncated by reset SHALL be dropped without emitting tlast; upstream is responsible for re-sending it.

Configuration
REQ-023 With macro CTRL_ARB_TIMEOUT_EN defined, a GRANT state with TIMEOUT_CYCLES consecutive cycles without an accepted beat SHALL emit one abort beat (tvalid=1, tlast=1, tkeep=0, tdata=0, tuser=0), set timeout_err, return to IDLE, and update last_grant.
REQ-024 With CTRL_ARB_TIMEOUT_EN defined, the abort SHALL NOT increment pkt_cnt, and the watchdog counter SHALL clear on every accepted beat and in IDLE.
REQ-025 Without CTRL_ARB_TIMEOUT_EN, the watchdog SHALL not be built, a grant SHALL be held indefinitely, and timeout_err SHALL be tied to 0.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the default widths 512/128.
REQ-027 The block SHALL have one sub-module, ctrl_arb_rr, as a 2-input round-robin grant picker taking request vector and last_grant and returning a one-hot grant.

Verification
REQ-028 Bench scenario: s0 sends a 3-beat packet, s1 idle -> output is 3 beats, delayed 1 cycle, tlast on beat 3, pkt_cnt=1.
REQ-029 Bench scenario: s0 and s1 both valid at reset release -> s0 packet fully out, 1 bubble cycle, then s1 packet; beats never interleave.
REQ-030 Bench scenario: s1 holds tvalid continuously while s0 sends back-to-back packets -> grants alternate s0,s1,s0.
REQ-031 Bench scenario: s0 drops tvalid for 5 cycles mid-packet -> no output beats for those cycles, s1 tready stays 0.
REQ-032 Bench scenario: aresetn asserted mid-packet -> all outputs 0 in the same cycle, pkt_cnt=0, and a fresh packet after release is forwarded intact.
REQ-033 Bench scenario, with CTRL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: s0 stalls after beat 1 -> abort beat emitted with tlast=1 and tkeep=0, timeout_err=1, and pending s1 is granted next.

Source files
------------

// File: rtl/ctrl_path_arbiter_pkg.sv
// Shared definitions for the control-path arbiter: FSM state encoding,
// default stream widths and a small state helper.
package ctrl_path_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   localparam int DEF_DATA_WIDTH  = 512;
   localparam int DEF_TUSER_WIDTH = 128;

   function automatic arb_state_e grant_state(input logic idx);
      return idx ? GRANT1 : GRANT0;
   endfunction

endpackage

// File: rtl/ctrl_path_arbiter_rr.sv
// Two-input round-robin grant picker: a lone request wins outright, a tie goes
// to the requester that did not hold the previous grant.
module ctrl_arb_rr (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      // NOTE: assign a default before the case so every path drives gnt_o and no latch is inferred.
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/ctrl_path_arbiter.sv
// Packet-atomic round-robin merge of two control streams onto one registered
// stream. Optional grant watchdog built when CTRL_ARB_TIMEOUT_EN is defined.
module ctrl_path_arbiter
   import ctrl_path_arbiter_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                              axis_clk,
   input  logic                              aresetn,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
   input  logic                              s0_axis_tvalid,
   input  logic                              s0_axis_tlast,
   output logic                              s0_axis_tready,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
   input  logic                              s1_axis_tvalid,
   input  logic                              s1_axis_tlast,
   output logic                              s1_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
   output logic                              c_m_axis_tvalid,
   output logic                              c_m_axis_tlast,

   output logic                              cfg_busy,
   output logic [31:0]                       pkt_cnt,
   output logic                              timeout_err
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

   arb_state_e      state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [31:0]     pkt_cnt_q, pkt_cnt_d;

   logic [DW-1:0]   tdata_q, tdata_d;
   logic [UW-1:0]   tuser_q, tuser_d;
   logic [KW-1:0]   tkeep_q, tkeep_d;
   logic            tvalid_q, tvalid_d;
   logic            tlast_q, tlast_d;

   logic [1:0]      rr_gnt;
   logic            gnt_idx;
   logic            acc_valid;
   logic            abort;

   logic [DW-1:0]   sel_tdata;
   logic [UW-1:0]   sel_tuser;
   logic [KW-1:0]   sel_tkeep;
   logic            sel_tlast;

   ctrl_arb_rr u_rr (
      .req_i        ({s1_axis_tvalid, s0_axis_tvalid}),
      .last_grant_i (last_grant_q),
      .gnt_o        (rr_gnt)
   );

   // tready depends only on registered state, so reset drops it at once.
   assign s0_axis_tready = (state_q == GRANT0);
   assign s1_axis_tready = (state_q == GRANT1);
   assign gnt_idx        = (state_q == GRANT1);
   assign acc_valid      = (s0_axis_tready & s0_axis_tvalid) |
                           (s1_axis_tready & s1_axis_tvalid);

   always_comb begin
      sel_tdata = s0_axis_tdata;
      sel_tuser = s0_axis_tuser;
      sel_tkeep = s0_axis_tkeep;
      sel_tlast = s0_axis_tlast;
      if (gnt_idx) begin
         sel_tdata = s1_axis_tdata;
         sel_tuser = s1_axis_tuser;
         sel_tkeep = s1_axis_tkeep;
         sel_tlast = s1_axis_tlast;
      end
   end

`ifdef CTRL_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_err_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive granted cycle with no accepted beat.
   assign abort = (state_q != IDLE) && !acc_valid &&
                  (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_cnt_d = '0;
      if ((state_q != IDLE) && !acc_valid && !abort) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_q | abort;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      pkt_cnt_d    = pkt_cnt_q;

      // Abort beat carries only tvalid/tlast; idle cycles drive the payload to zero.
      tvalid_d = acc_valid | abort;
      tlast_d  = (acc_valid & sel_tlast) | abort;
      tdata_d  = acc_valid ? sel_tdata : '0;
      tuser_d  = acc_valid ? sel_tuser : '0;
      tkeep_d  = acc_valid ? sel_tkeep : '0;

      case (state_q)
         IDLE: begin
            if (rr_gnt[0]) begin
               state_d = grant_state(1'b0);
            end else if (rr_gnt[1]) begin
               state_d = grant_state(1'b1);
            end
         end
         GRANT0, GRANT1: begin
            if ((acc_valid && sel_tlast) || abort) begin
               state_d      = IDLE;
               last_grant_d = gnt_idx;
               if (!abort) begin
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         pkt_cnt_q    <= '0;
         tdata_q      <= '0;
         tuser_q      <= '0;
         tkeep_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         pkt_cnt_q    <= pkt_cnt_d;
         tdata_q      <= tdata_d;
         tuser_q      <= tuser_d;
         tkeep_q      <= tkeep_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
      end
   end

   assign c_m_axis_tdata  = tdata_q;
   assign c_m_axis_tuser  = tuser_q;
   assign c_m_axis_tkeep  = tkeep_q;
   assign c_m_axis_tvalid = tvalid_q;
   assign c_m_axis_tlast  = tlast_q;
   assign cfg_busy        = (state_q != IDLE);
   assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_ctrl_path_arbiter.sv
// Scoreboard bench for ctrl_path_arbiter: drivers push expected beats on
// acceptance, a negedge monitor pops and compares every output beat.
`timescale 1ns/1ps
module tb_ctrl_path_arbiter;

   localparam int DW = 32;
   localparam int UW = 16;
   localparam int KW = DW / 8;
   localparam int TO = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          axis_clk = 1'b0;
   logic          aresetn  = 1'b0;

   logic [DW-1:0] s_tdata  [2];
   logic [UW-1:0] s_tuser  [2];
   logic [KW-1:0] s_tkeep  [2];
   logic          s_tvalid [2];
   logic          s_tlast  [2];
   logic          s0_tready, s1_tready;

   logic [DW-1:0] m_tdata;
   logic [UW-1:0] m_tuser;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid, m_tlast;
   logic          cfg_busy, timeout_err;
   logic [31:0]   pkt_cnt;

   beat_t         exp_q[$];
   int            src_log[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            exp_pkts = 0;
   logic          prev_last = 1'b0;
   beat_t         mon_e;

   always #5 axis_clk = ~axis_clk;

   ctrl_path_arbiter #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .TIMEOUT_CYCLES       (TO)
   ) dut (
      .axis_clk        (axis_clk),
      .aresetn         (aresetn),
      .s0_axis_tdata   (s_tdata[0]),
      .s0_axis_tuser   (s_tuser[0]),
      .s0_axis_tkeep   (s_tkeep[0]),
      .s0_axis_tvalid  (s_tvalid[0]),
      .s0_axis_tlast   (s_tlast[0]),
      .s0_axis_tready  (s0_tready),
      .s1_axis_tdata   (s_tdata[1]),
      .s1_axis_tuser   (s_tuser[1]),
      .s1_axis_tkeep   (s_tkeep[1]),
      .s1_axis_tvalid  (s_tvalid[1]),
      .s1_axis_tlast   (s_tlast[1]),
      .s1_axis_tready  (s1_tready),
      .c_m_axis_tdata  (m_tdata),
      .c_m_axis_tuser  (m_tuser),
      .c_m_axis_tkeep  (m_tkeep),
      .c_m_axis_tvalid (m_tvalid),
      .c_m_axis_tlast  (m_tlast),
      .cfg_busy        (cfg_busy),
      .pkt_cnt         (pkt_cnt),
      .timeout_err     (timeout_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic tready(input int n);
      return (n == 0) ? s0_tready : s1_tready;
   endfunction

   function automatic beat_t mk_beat(input int n, input int pid, input int b, input bit last);
      beat_t x;
      x.data = {8'(n + 1), 8'(pid), 8'(b), 8'hC3};
      x.user = {8'(n + 1), 8'(pid)};
      x.keep = last ? 4'b0111 : 4'b1111;
      x.last = last;
      return x;
   endfunction

   // Grant order as a decimal code: each forwarded packet appends (source+1).
   function automatic int log_code();
      int c = 0;
      foreach (src_log[i]) c = c * 10 + src_log[i] + 1;
      return c;
   endfunction

   task automatic drive(input int n, input beat_t x);
      s_tdata[n]  = x.data;
      s_tuser[n]  = x.user;
      s_tkeep[n]  = x.keep;
      s_tlast[n]  = x.last;
      s_tvalid[n] = 1'b1;
   endtask

   task automatic idle_src(input int n);
      s_tdata[n]  = '0;
      s_tuser[n]  = '0;
      s_tkeep[n]  = '0;
      s_tlast[n]  = 1'b0;
      s_tvalid[n] = 1'b0;
   endtask

   // Entered just after a negedge with the beat driven; returns one negedge after acceptance.
   task automatic wait_accept(input int n, input beat_t x, output bit ok);
      int guard = 0;
      ok = 1'b0;
      while (!tready(n) && guard < 200) begin
         @(negedge axis_clk);
         guard++;
      end
      if (!tready(n)) begin
         check($sformatf("accept_timeout_s%0d", n), 64'(tready(n)), 64'd1);
      end else begin
         exp_q.push_back(x);
         if (x.last) exp_pkts++;
         @(negedge axis_clk);
         ok = 1'b1;
      end
   endtask

   task automatic send_pkt(input int n, input int pid, input int nbeats,
                           input int stall_at, input int stall_len);
      bit    ok;
      beat_t x;
      for (int b = 0; b < nbeats; b++) begin
         if (b == stall_at && stall_len > 0) begin
            idle_src(n);
            repeat (stall_len) begin
               @(negedge axis_clk);
               check("stall_no_output",    64'(m_tvalid),        64'd0);
               check("stall_hold_grant",   64'(tready(n)),       64'd1);
               check("stall_other_tready", 64'(tready(1 - n)),   64'd0);
            end
         end
         x = mk_beat(n, pid, b, (b == nbeats - 1));
         drive(n, x);
         wait_accept(n, x, ok);
         if (!ok) begin
            idle_src(n);
            return;
         end
      end
      idle_src(n);
   endtask

   task automatic drain();
      repeat (4) @(negedge axis_clk);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge axis_clk) begin
      check("tready_exclusive", 64'(s0_tready & s1_tready), 64'd0);
      if (prev_last) check("bubble_after_last", 64'(m_tvalid), 64'd0);
      if (m_tvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_tvalid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("beat_tdata", 64'(m_tdata), 64'(mon_e.data));
            check("beat_tuser", 64'(m_tuser), 64'(mon_e.user));
            check("beat_tkeep", 64'(m_tkeep), 64'(mon_e.keep));
            check("beat_tlast", 64'(m_tlast), 64'(mon_e.last));
         end
         if (m_tlast && m_tuser[UW-1:8] != 8'd0) src_log.push_back(int'(m_tuser[UW-1:8]) - 1);
      end else begin
         check("idle_payload_zero", 64'({m_tdata, m_tuser, m_tkeep, m_tlast}), 64'd0);
      end
      prev_last = m_tvalid & m_tlast;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete, expected finish before 200000ns");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      bit    ok;
      beat_t x;
      beat_t abort_b;
      idle_src(0);
      idle_src(1);
      aresetn = 1'b0;
      repeat (2) @(negedge axis_clk);

      check("rst_tvalid",      64'(m_tvalid),    64'd0);
      check("rst_s0_tready",   64'(s0_tready),   64'd0);
      check("rst_pkt_cnt",     64'(pkt_cnt),     64'd0);
      check("rst_busy",        64'(cfg_busy),    64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      aresetn = 1'b1;
      @(negedge axis_clk);

      // Single 3-beat packet from s0.
      send_pkt(0, 1, 3, -1, 0);
      check("single_busy_during_tail", 64'(cfg_busy), 64'd0);
      drain();
      check("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // Both requesters valid across reset release: s0 wins the first tie.
      aresetn = 1'b0;
      exp_pkts = 0;
      src_log.delete();
      @(negedge axis_clk);
      check("rst2_pkt_cnt", 64'(pkt_cnt), 64'd0);
      fork
         send_pkt(0, 2, 3, -1, 0);
         send_pkt(1, 3, 2, -1, 0);
         begin @(negedge axis_clk); aresetn = 1'b1; end
      join
      drain();
      check("tie_order",   64'(log_code()), 64'd12);
      check("tie_pkt_cnt", 64'(pkt_cnt),    64'(exp_pkts));

      // s1 held valid while s0 streams back-to-back packets: grants alternate.
      src_log.delete();
      fork
         begin send_pkt(0, 4, 2, -1, 0); send_pkt(0, 5, 2, -1, 0); end
         send_pkt(1, 6, 3, -1, 0);
      join
      drain();
      check("rr_order",   64'(log_code()), 64'd121);
      check("rr_pkt_cnt", 64'(pkt_cnt),    64'(exp_pkts));

      // s0 drops tvalid for 5 cycles mid-packet while s1 is pending.
      src_log.delete();
      fork
         send_pkt(0, 7, 4, 2, 5);
         begin repeat (2) @(negedge axis_clk); send_pkt(1, 8, 2, -1, 0); end
      join
      drain();
      check("stall_order",       64'(log_code()),  64'd12);
      check("stall_pkt_cnt",     64'(pkt_cnt),     64'(exp_pkts));
      check("stall_timeout_err", 64'(timeout_err), 64'd0);

      // Reset asserted mid-packet: outputs clear at once, packet is dropped.
      x = mk_beat(0, 9, 0, 1'b0);
      drive(0, x);
      wait_accept(0, x, ok);
      x = mk_beat(0, 9, 1, 1'b0);
      drive(0, x);
      wait_accept(0, x, ok);
      #2;
      aresetn = 1'b0;
      idle_src(0);
      #1;
      check("midrst_tvalid",  64'(m_tvalid),  64'd0);
      check("midrst_payload", 64'({m_tdata, m_tuser, m_tkeep, m_tlast}), 64'd0);
      check("midrst_tready",  64'({s0_tready, s1_tready}), 64'd0);
      check("midrst_pkt_cnt", 64'(pkt_cnt),   64'd0);
      check("midrst_busy",    64'(cfg_busy),  64'd0);
      exp_q.delete();
      exp_pkts = 0;
      @(negedge axis_clk);
      aresetn = 1'b1;
      @(negedge axis_clk);
      send_pkt(0, 10, 3, -1, 0);
      drain();
      check("postrst_pkt_cnt", 64'(pkt_cnt), 64'd1);

`ifdef CTRL_ARB_TIMEOUT_EN
      // s0 stalls after one beat: watchdog aborts, then pending s1 is served.
      src_log.delete();
      check("pre_timeout_err", 64'(timeout_err), 64'd0);
      x = mk_beat(0, 11, 0, 1'b0);
      drive(0, x);
      wait_accept(0, x, ok);
      idle_src(0);
      abort_b      = '0;
      abort_b.last = 1'b1;
      exp_q.push_back(abort_b);
      send_pkt(1, 12, 2, -1, 0);
      drain();
      check("timeout_err_set",   64'(timeout_err), 64'd1);
      check("timeout_pkt_cnt",   64'(pkt_cnt),     64'(exp_pkts));
      check("timeout_next_s1",   64'(log_code()),  64'd2);
`endif

      check("sb_empty_final", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
